// File: rtl/countdown_pkg.sv
// Shared types and constants for the M:SS.d countdown timer.
// Optional alarm timer: COUNTDOWN_ALARM_EN.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        DONE
    } state_e;

    localparam int MIN1_MAX  = 9;
    localparam int SEC10_MAX = 5;
    localparam int SEC1_MAX  = 9;
    localparam int MS100_MAX = 9;

    localparam int ALARM_TICKS_DEF = 30;

endpackage

// File: rtl/countdown_gy_bcd_down.sv
// Single BCD down-counting digit with saturating load.
// Wraps 0 -> MAX when decremented; the caller gates dec.
module gy_bcd_down
    import countdown_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       dec,
    output logic [3:0] q,
    output logic       zero
);

    localparam logic [3:0] MAXV = 4'(MAX);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (d > MAXV) ? MAXV : d;
        end else if (dec) begin
            q_d = (q_q == 4'd0) ? MAXV : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign zero = (q_q == 4'd0);

endmodule

// File: rtl/countdown_gy.sv
// M:SS.d countdown timer: four BCD digits plus IDLE/HOLD/RUN/DONE FSM.
// Optional alarm output and DONE timer: COUNTDOWN_ALARM_EN.
module countdown_gy
    import countdown_pkg::*;
#(
    parameter int ALARM_TICKS = ALARM_TICKS_DEF
) (
    input  logic       clk_10Hz,
    input  logic       clr_n,
    input  logic       load,
    input  logic [3:0] in_min1,
    input  logic [3:0] in_sec10,
    input  logic [3:0] in_sec1,
    input  logic [3:0] in_ms100,
    input  logic       en,
    output logic [3:0] min1,
    output logic [3:0] sec10,
    output logic [3:0] sec1,
    output logic [3:0] ms100,
    output logic       running,
    output logic       done
`ifdef COUNTDOWN_ALARM_EN
    ,
    output logic       alarm
`endif
);

    state_e state_q;
    logic   running_q;
    logic   done_q;

`ifdef COUNTDOWN_ALARM_EN
    localparam int TW = $clog2(ALARM_TICKS + 1);
    logic [TW-1:0] timer_q;
    logic          alarm_q;
`endif

    logic z_m, z_s10, z_s1, z_ms;
    logic cnt, en_s1, en_s10, en_m;
    logic last, pre_zero;

    // Saturation keeps zero digits zero, so the raw preset decides IDLE.
    assign pre_zero = (in_min1 == 4'd0) && (in_sec10 == 4'd0) &&
                      (in_sec1 == 4'd0) && (in_ms100 == 4'd0);

    assign last = z_m && z_s10 && z_s1 && (ms100 == 4'd1);

    assign cnt    = !load && en &&
                    ((state_q == HOLD) || (state_q == RUN));
    assign en_s1  = cnt && z_ms;
    assign en_s10 = en_s1 && z_s1;
    assign en_m   = en_s10 && z_s10;

    gy_bcd_down #(.MAX(MS100_MAX)) u_ms100 (
        .clk(clk_10Hz), .rst_n(clr_n), .load(load), .d(in_ms100),
        .dec(cnt), .q(ms100), .zero(z_ms)
    );
    gy_bcd_down #(.MAX(SEC1_MAX)) u_sec1 (
        .clk(clk_10Hz), .rst_n(clr_n), .load(load), .d(in_sec1),
        .dec(en_s1), .q(sec1), .zero(z_s1)
    );
    gy_bcd_down #(.MAX(SEC10_MAX)) u_sec10 (
        .clk(clk_10Hz), .rst_n(clr_n), .load(load), .d(in_sec10),
        .dec(en_s10), .q(sec10), .zero(z_s10)
    );
    gy_bcd_down #(.MAX(MIN1_MAX)) u_min1 (
        .clk(clk_10Hz), .rst_n(clr_n), .load(load), .d(in_min1),
        .dec(en_m), .q(min1), .zero(z_m)
    );

    always_ff @(posedge clk_10Hz or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef COUNTDOWN_ALARM_EN
            timer_q   <= '0;
            alarm_q   <= 1'b0;
`endif
        end else if (load) begin
            state_q   <= pre_zero ? IDLE : HOLD;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef COUNTDOWN_ALARM_EN
            timer_q   <= '0;
            alarm_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                HOLD, RUN: begin
                    if (!en) begin
                        state_q   <= HOLD;
                        running_q <= 1'b0;
                    end else if (last) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
`ifdef COUNTDOWN_ALARM_EN
                        timer_q   <= TW'(1);
                        alarm_q   <= 1'b1;
`endif
                    end else begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                DONE: begin
`ifdef COUNTDOWN_ALARM_EN
                    if (timer_q == TW'(ALARM_TICKS)) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        alarm_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
`else
                    state_q <= IDLE;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign running = running_q;
    assign done    = done_q;
`ifdef COUNTDOWN_ALARM_EN
    assign alarm   = alarm_q;
`endif

endmodule

// File: tb/tb_countdown_gy.sv
// Directed self-checking bench for countdown_gy.
// Alarm steps run only when COUNTDOWN_ALARM_EN is defined.
module tb_countdown_gy;

    logic       clk_10Hz = 1'b0;
    logic       clr_n = 1'b0;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic [3:0] in_min1 = 4'd0, in_sec10 = 4'd0;
    logic [3:0] in_sec1 = 4'd0, in_ms100 = 4'd0;
    logic [3:0] min1, sec10, sec1, ms100;
    logic       running, done;
    logic       alarm;
    int         errors = 0;
    int         checks = 0;

    always #5 clk_10Hz = ~clk_10Hz;

`ifdef COUNTDOWN_ALARM_EN
    countdown_gy #(.ALARM_TICKS(4)) dut (
        .clk_10Hz(clk_10Hz), .clr_n(clr_n), .load(load),
        .in_min1(in_min1), .in_sec10(in_sec10),
        .in_sec1(in_sec1), .in_ms100(in_ms100), .en(en),
        .min1(min1), .sec10(sec10), .sec1(sec1), .ms100(ms100),
        .running(running), .done(done), .alarm(alarm)
    );
`else
    assign alarm = 1'b0;
    countdown_gy dut (
        .clk_10Hz(clk_10Hz), .clr_n(clr_n), .load(load),
        .in_min1(in_min1), .in_sec10(in_sec10),
        .in_sec1(in_sec1), .in_ms100(in_ms100), .en(en),
        .min1(min1), .sec10(sec10), .sec1(sec1), .ms100(ms100),
        .running(running), .done(done)
    );
`endif

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [15:0] exp);
        chk(tag, {min1, sec10, sec1, ms100}, exp);
    endtask

    task automatic set_pre(input logic [15:0] v);
        {in_min1, in_sec10, in_sec1, in_ms100} = v;
    endtask

    task automatic tick();
        @(posedge clk_10Hz);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        set_pre(v);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        #1;
        chk_val("reset_val", 16'h0000);
        chk("reset_run", {15'd0, running}, 16'd0);
        chk("reset_done", {15'd0, done}, 16'd0);
        chk("reset_alarm", {15'd0, alarm}, 16'd0);
        #1 clr_n = 1'b1;

        do_load(16'h3275);
        chk_val("load_3275", 16'h3275);
        chk("load_run0", {15'd0, running}, 16'd0);
        en = 1'b1;
        tick();
        chk_val("run_3274", 16'h3274);
        chk("run_run1", {15'd0, running}, 16'd1);
        #2 clr_n = 1'b0;
        #1;
        chk_val("async_clr_val", 16'h0000);
        chk("async_clr_run", {15'd0, running}, 16'd0);
        clr_n = 1'b1;
        en = 1'b0;

        do_load(16'h1000);
        chk_val("load_1000", 16'h1000);
        en = 1'b1;
        tick();
        en = 1'b0;
        chk_val("borrow_0599", 16'h0599);

        do_load(16'h0003);
        en = 1'b1;
        tick();
        chk_val("cd_0002", 16'h0002);
        chk("cd_done_a", {15'd0, done}, 16'd0);
        tick();
        chk_val("cd_0001", 16'h0001);
        tick();
        chk_val("cd_0000", 16'h0000);
        chk("cd_done_1", {15'd0, done}, 16'd1);
        chk("cd_run_0", {15'd0, running}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_val("cd_hold0", 16'h0000);
            chk("cd_done_0", {15'd0, done}, 16'd0);
        end
        en = 1'b0;

        do_load(16'hF7CA);
        chk_val("sat_9599", 16'h9599);
        do_load(16'h0000);
        chk_val("load_zero", 16'h0000);
        en = 1'b1;
        tick();
        tick();
        chk_val("idle_en_val", 16'h0000);
        chk("idle_en_run", {15'd0, running}, 16'd0);
        chk("idle_en_done", {15'd0, done}, 16'd0);
        en = 1'b0;

        do_load(16'h0100);
        en = 1'b1;
        repeat (5) tick();
        chk_val("pause_0095", 16'h0095);
        chk("pause_run1", {15'd0, running}, 16'd1);
        en = 1'b0;
        tick();
        chk_val("frozen_a", 16'h0095);
        chk("frozen_run0", {15'd0, running}, 16'd0);
        tick();
        chk_val("frozen_b", 16'h0095);
        en = 1'b1;
        repeat (2) tick();
        chk_val("resume_0093", 16'h0093);
        en = 1'b0;

        do_load(16'h0002);
        en = 1'b1;
        tick();
        chk_val("exp_0001", 16'h0001);
        set_pre(16'h0050);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk_val("ldexp_val", 16'h0050);
        chk("ldexp_done", {15'd0, done}, 16'd0);
        chk("ldexp_run", {15'd0, running}, 16'd0);
        tick();
        chk_val("ldexp_next", 16'h0049);
        en = 1'b0;

`ifdef COUNTDOWN_ALARM_EN
        do_load(16'h0001);
        en = 1'b1;
        tick();
        chk("al_done", {15'd0, done}, 16'd1);
        chk("al_k", {15'd0, alarm}, 16'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("al_hold", {15'd0, alarm}, 16'd1);
        end
        tick();
        chk("al_off", {15'd0, alarm}, 16'd0);
        tick();
        chk("al_idle", {15'd0, alarm}, 16'd0);
        chk_val("al_val", 16'h0000);

        do_load(16'h0001);
        tick();
        chk("al2_on", {15'd0, alarm}, 16'd1);
        tick();
        chk("al2_hold", {15'd0, alarm}, 16'd1);
        set_pre(16'h0020);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("al2_clr", {15'd0, alarm}, 16'd0);
        chk_val("al2_val", 16'h0020);
        en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
